// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared constants and FSM state encoding for the fetch queue
package inst_fetch_queue_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0001_0000;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: imem request/ack bus plus pipeline-side queue head and redirect
interface inst_fetch_queue_if;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemAck;
  logic [31:0] i_imemData;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_PC;
  logic        i_ready;
  logic        i_redirect;
  logic [31:0] i_redirectPC;
  modport master (
    output o_imemReq, o_imemAddr, o_valid, o_inst, o_PC,
    input  i_imemAck, i_imemData, i_ready, i_redirect, i_redirectPC
  );
  modport slave (
    input  o_imemReq, o_imemAddr, o_valid, o_inst, o_PC,
    output i_imemAck, i_imemData, i_ready, i_redirect, i_redirectPC
  );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// inst_fetch_queue_fetch_fifo: DEPTH x 64 {PC, inst} FIFO with synchronous flush and combinational head
module inst_fetch_queue_fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_x,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [63:0]                  din,
  output logic [63:0]                  head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign head = mem[rd];
  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= rd + AW'(pop);
      wr    <= wr + AW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  // requests are only issued with room, so a push into a full queue is a design error
  always_ff @(posedge clk)
    if (reset_x && push && !pop && !flush) assert (count != CW'(DEPTH));
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC owner issuing imem req/ack fetches into a flushable instruction queue
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset_x,
  inst_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [1:0]    state, state_nxt;
  logic [31:0]   fetch_pc, req_addr;
  logic [CW-1:0] count, count_nxt;
  logic [63:0]   head;
  logic          push, pop, redir, ack, valid;
  assign ack       = bus.i_imemAck;
  assign redir     = bus.i_redirect;
  assign valid     = count != '0;
  assign pop       = valid && bus.i_ready && !redir;
  assign push      = state == WAIT && ack && !redir;
  assign count_nxt = count + CW'(1) - CW'(pop);
  inst_fetch_queue_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_x(reset_x), .push(push), .pop(pop), .flush(redir),
    .din({req_addr, bus.i_imemData}), .head(head), .count(count)
  );
  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x) state <= IDLE;
    else state <= state_nxt;
  // a redirect without ack must keep the request alive until the memory takes it
  always_comb begin
    state_nxt = state == IDLE ? ((!redir && count < FULL) ? WAIT : IDLE) :
                state == WAIT ? (ack ? ((!redir && count_nxt < FULL) ? WAIT : IDLE) : (redir ? DROP : WAIT)) :
                (ack ? IDLE : DROP);
  end
  always_comb begin
    bus.o_imemReq  = state == WAIT || state == DROP;
    bus.o_imemAddr = req_addr;
    bus.o_valid    = valid;
    bus.o_inst     = valid ? head[31:0] : NOP;
    bus.o_PC       = valid ? head[63:32] : 32'h0;
  end
  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (redir) fetch_pc <= bus.i_redirectPC & ~32'h3;
      else if (push) fetch_pc <= req_addr + 32'd4;
      if (state_nxt == WAIT) req_addr <= state == IDLE ? fetch_pc : push ? req_addr + 32'd4 : req_addr;
    end
endmodule
